// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer.
// Registered in_ready and out_data, flush to NOP, saturating stall counter.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   flush                : discard held beats and the incoming beat
//   out_valid/out_ready  : downstream handshake, out_data payload
//   stall_cnt            : cycles with out_valid & !out_ready
module pipe_stage_skid #(
    parameter int DATA_W = 48,
    parameter int INSTR_W = 16,
    parameter logic [INSTR_W-1:0] NOP_VAL = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int META_W = DATA_W - INSTR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;
    logic              stall;

    // in_ready comes straight from the skid valid flop, so there
    // is no combinational path from out_ready back to in_ready.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    assign in_fire  = in_valid & ~skid_valid;
    assign out_fire = main_valid & out_ready;
    assign stall    = main_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= {{META_W{1'b0}}, NOP_VAL};
            skid_data  <= '0;
            stall_cnt  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data[INSTR_W-1:0] <= NOP_VAL;
            // Meta follows the beat being killed so sideband state
            // (e.g. PC) stays visible alongside the bubble.
            if (in_valid) begin
                main_data[DATA_W-1:INSTR_W] <= in_data[DATA_W-1:INSTR_W];
            end
        end else begin
            if (stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (skid_valid) begin
                // Skid refills main as the main beat drains.
                if (out_fire) begin
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end
            end else if (!main_valid || out_ready) begin
                if (in_fire) begin
                    main_data  <= in_data;
                    main_valid <= 1'b1;
                end else if (out_fire) begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed cases plus a
// random valid/ready/flush run against a queue-based model.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic [15:0] stall_cnt;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [47:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [47:0] s_out_data;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    bit chk_en = 0;
    bit rnd = 0;
    logic [31:0] last_seq = 0;

    logic [47:0] q[$];
    logic [47:0] hold;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .flush(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] shown();
        return (q.size() > 0) ? q[0] : hold;
    endfunction

    // Model: the stage is a FIFO of depth two; out_data shows the
    // head, or the last value left in the output register.
    task automatic model_step();
        bit acc;
        bit pop;
        logic [47:0] cur;
        cur = shown();
        if (!rst_n) begin
            q.delete();
            hold = 48'h0;
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
            hold = {in_valid ? in_data[47:16] : cur[47:16], 16'h0000};
        end else begin
            acc = in_valid && (q.size() < 2);
            pop = (q.size() > 0) && out_ready;
            if (q.size() > 0 && !out_ready && m_cnt != 16'hFFFF) m_cnt++;
            if (pop) begin
                hold = q.pop_front();
                delivered++;
            end
            if (acc) q.push_back(in_data);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("out_valid", {63'h0, out_valid}, {63'h0, q.size() > 0});
            chk("in_ready", {63'h0, in_ready}, {63'h0, q.size() < 2});
            chk("out_data", {16'h0, out_data}, {16'h0, shown()});
            chk("stall_cnt", {48'h0, stall_cnt}, {48'h0, m_cnt});
            if (rnd && out_valid && out_ready) begin
                chk("order", {63'h0, out_data[47:16] > last_seq}, 64'h1);
                last_seq = out_data[47:16];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick();
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
        s_in_valid = 0; s_in_data = 48'h5; s_out_ready = 1;
        tick();
        chk_en = 1;
        tick();
        rst_n = 1;
        chk("rst_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_data", {16'h0, out_data}, 64'h0);
        chk("rst_cnt", {48'h0, stall_cnt}, 64'h0);

        out_ready = 1;
        send(48'h0001_0002_1234);
        chk("str_d1", {16'h0, out_data}, 64'h0001_0002_1234);
        send(48'h0003_0004_5678);
        chk("str_d2", {16'h0, out_data}, 64'h0003_0004_5678);
        chk("str_v2", {63'h0, out_valid}, 64'h1);
        in_valid = 0;
        tick();
        chk("str_v3", {63'h0, out_valid}, 64'h0);
        chk("str_cnt", {48'h0, stall_cnt}, 64'h0);

        out_ready = 0;
        send(48'hA);
        send(48'hB);
        in_valid = 0;
        chk("bp_ready", {63'h0, in_ready}, 64'h0);
        tick();
        chk("bp_hold", {16'h0, out_data}, 64'hA);
        chk("bp_cnt", {48'h0, stall_cnt}, 64'h2);
        out_ready = 1;
        tick();
        chk("bp_b", {16'h0, out_data}, 64'hB);
        chk("bp_bv", {63'h0, out_valid}, 64'h1);
        tick();
        chk("bp_empty", {63'h0, out_valid}, 64'h0);

        out_ready = 0;
        send(48'hA);
        send(48'hB);
        flush = 1;
        send(48'h0040_0042_FFFF);
        flush = 0;
        in_valid = 0;
        chk("fl_valid", {63'h0, out_valid}, 64'h0);
        chk("fl_ready", {63'h0, in_ready}, 64'h1);
        chk("fl_data", {16'h0, out_data}, 64'h0040_0042_0000);
        chk("fl_cnt", {48'h0, stall_cnt}, 64'h3);

        rst_n = 0;
        tick();
        rst_n = 1;
        send(48'h11);
        send(48'h22);
        in_valid = 0;
        repeat (6) tick();
        chk("mid_cnt", {48'h0, stall_cnt}, 64'h7);
        chk("mid_full", {63'h0, in_ready}, 64'h0);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_valid", {63'h0, out_valid}, 64'h0);
        chk("mid_ready", {63'h0, in_ready}, 64'h1);
        chk("mid_cnt0", {48'h0, stall_cnt}, 64'h0);
        chk("mid_data", {16'h0, out_data}, 64'h0);

        rnd = 1;
        delivered = 0;
        for (int c = 1; c < 40000 && delivered < 10000; c++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 300) == 0;
            in_data = {c[31:0], 16'($urandom)};
            tick();
        end
        in_valid = 0;
        flush = 0;
        out_ready = 1;
        repeat (3) tick();
        rnd = 0;
        chk("rnd_beats", {63'h0, delivered >= 10000}, 64'h1);

        s_in_valid = 1;
        tick();
        s_in_valid = 0;
        s_out_ready = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat_cnt", {60'h0, s_stall_cnt}, (k < 15) ? 64'(k) : 64'd15);
        end
        chk("sat_valid", {63'h0, s_out_valid}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 48: payload width, {meta[DATA_W-1:INSTR_W], instr[INSTR_W-1:0]}.
REQ-002 SHALL have parameter INSTR_W, default 16: instruction field width; INSTR_W < DATA_W.
REQ-003 SHALL have parameter NOP_VAL, default 16'h0000 (INSTR_W bits): instruction substituted on flush/reset.
REQ-004 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  in  1  upstream beat valid.
REQ-008 SHALL have port in_ready  out  1  stage can accept; driven from a register only.
REQ-009 SHALL have port in_data  in  DATA_W  upstream payload.
REQ-010 SHALL have port flush  in  1  kill all held beats and the incoming beat.
REQ-011 SHALL have port out_valid  out  1  output beat valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts.
REQ-013 SHALL have port out_data  out  DATA_W  output payload, driven from a register.
REQ-014 SHALL have port stall_cnt  out  CNT_W  count of back-pressured cycles.

Function
REQ-015 SHALL hold two entries: main (drives out_*) and skid; each has a valid bit and DATA_W data.
REQ-016 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; a transfer occurs only on fire.
REQ-017 SHALL drive in_ready = !skid_valid, so it does not combinationally depend on out_ready.
REQ-018 SHALL have 1-cycle latency: a beat accepted in cycle N with main empty or draining appears on out_data in cycle N+1.
REQ-019 SHALL sustain one beat per cycle when out_ready stays high.
REQ-020 SHALL, on in_fire with main empty or out_fire and skid empty: main <= in_data, main_valid <= 1.
REQ-021 SHALL, on in_fire with main valid and !out_ready: skid <= in_data, skid_valid <= 1 (in_ready drops next cycle).
REQ-022 SHALL, on out_fire with skid valid: main <= skid, skid_valid <= 0; main_valid stays 1.
REQ-023 SHALL, on out_fire with no in_fire and skid empty: main_valid <= 0; out_data is retained.
REQ-024 SHALL preserve beat order; no beat is duplicated or lost except by flush.
REQ-025 SHALL, on flush (priority over all transfers): main_valid <= 0, skid_valid <= 0, main instr <= NOP_VAL, main meta <= in_data meta if in_valid, else meta is retained.
REQ-026 SHALL treat any beat presented during a flush cycle as discarded; in_ready is not modified combinationally by flush.
REQ-027 SHALL keep out_data stable while out_valid & !out_ready.
REQ-028 SHALL increment stall_cnt by 1 each cycle with out_valid & !out_ready, saturate at 2^CNT_W-1, and never wrap.
REQ-029 SHALL not update stall_cnt on flush cycles.

Reset
REQ-030 SHALL, when rst_n=0 at a clk edge, set main_valid=0, skid_valid=0, out_data={0, NOP_VAL}, skid data=0, in_ready=1 and stall_cnt=0; reset overrides flush and all transfers.
REQ-031 SHALL fully apply reset asserted mid-operation (entries full) in one cycle; beats held at that time are dropped.

Verification
REQ-032 SHALL pass streaming: out_ready=1, in_data 48'h0001_0002_1234 then 48'h0003_0004_5678 on consecutive cycles -> out_data equals each value 1 cycle later, out_valid=1 for 2 cycles, stall_cnt=0.
REQ-033 SHALL pass back-pressure: out_ready=0, send A=48'hA, B=48'hB -> A held on out_data, B in skid, in_ready=0; out_ready=1 -> A, then B on successive cycles; stall_cnt=2 after the stall.
REQ-034 SHALL pass full-stage flush: main=A, skid=B, flush=1 with in_valid=1, in_data=48'h0040_0042_FFFF -> next cycle out_valid=0, in_ready=1, out_data=48'h0040_0042_0000.
REQ-035 SHALL pass saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, no wrap to 0.
REQ-036 SHALL pass reset mid-operation: both entries full, stall_cnt=7, rst_n=0 one edge -> out_valid=0, in_ready=1, stall_cnt=0, out_data=48'h0000_0000_0000.
REQ-037 SHALL pass a random valid/ready scoreboard of 10k beats: output order matches input order, with no loss or duplication outside flush.
